// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined integer ALU: function encodings, default widths
// and the stage-entry layout.
// Optional feature macro: ALU_PIPE_ZBB_EN (enables MIN/MAX/MINU/MAXU/ANDN/ORN).
package alu_pipe_pkg;

  localparam int unsigned XlenDefault = 32;
  localparam int unsigned TagWDefault = 6;
  localparam int unsigned BmWDefault  = 4;

  // 4-bit function encoding; 10..15 only compute when ALU_PIPE_ZBB_EN is defined.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSlt  = 4'd2,
    AluSltu = 4'd3,
    AluAnd  = 4'd4,
    AluOr   = 4'd5,
    AluXor  = 4'd6,
    AluSll  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9,
    AluMin  = 4'd10,
    AluMax  = 4'd11,
    AluMinu = 4'd12,
    AluMaxu = 4'd13,
    AluAndn = 4'd14,
    AluOrn  = 4'd15
  } alu_func_e;

  // Stage entry at the default widths; the pipeline mirrors this layout at its own widths.
  typedef struct packed {
    logic                   valid;
    logic [XlenDefault-1:0] result;
    logic [TagWDefault-1:0] tag;
    logic [BmWDefault-1:0]  bmask;
  } stage_entry_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/CDB side signals of the pipelined ALU. master = issue/CDB side, slave = the ALU.
// Optional feature macro: ALU_PIPE_ZBB_EN (no effect on this interface).
interface alu_pipe_if #(
  parameter int unsigned XLEN  = alu_pipe_pkg::XlenDefault,
  parameter int unsigned TAG_W = alu_pipe_pkg::TagWDefault,
  parameter int unsigned BM_W  = alu_pipe_pkg::BmWDefault
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_opa;
  logic [XLEN-1:0]  in_opb;
  logic [3:0]       in_func;
  logic [TAG_W-1:0] in_tag;
  logic [BM_W-1:0]  in_bmask;
  logic             squash_valid;
  logic [BM_W-1:0]  squash_bmask;
  logic             resolve_valid;
  logic [BM_W-1:0]  resolve_bmask;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic [BM_W-1:0]  out_bmask;
  logic             busy;

  modport master (
    output in_valid, in_opa, in_opb, in_func, in_tag, in_bmask,
    output squash_valid, squash_bmask, resolve_valid, resolve_bmask, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_bmask, busy
  );

  modport slave (
    input  in_valid, in_opa, in_opb, in_func, in_tag, in_bmask,
    input  squash_valid, squash_bmask, resolve_valid, resolve_bmask, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_bmask, busy
  );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational RV32I/RV64I integer ALU: (opa, opb, func) -> result.
// Optional feature macro: ALU_PIPE_ZBB_EN adds MIN/MAX/MINU/MAXU/ANDN/ORN on 10..15.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [3:0]      func,
  output logic [XLEN-1:0] result
);
  localparam int unsigned ShW = $clog2(XLEN);

  logic [ShW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  // Shared comparators feed SLT/SLTU and, when enabled, the min/max ops.
  always_comb begin
    shamt = opb[ShW-1:0];
    lt_s  = $signed(opa) < $signed(opb);
    lt_u  = opa < opb;
  end

  // Function decode; unused encodings yield zero.
  always_comb begin
    result = '0;
    case (func)
      AluAdd:  result = opa + opb;
      AluSub:  result = opa - opb;
      AluSlt:  result = {{(XLEN-1){1'b0}}, lt_s};
      AluSltu: result = {{(XLEN-1){1'b0}}, lt_u};
      AluAnd:  result = opa & opb;
      AluOr:   result = opa | opb;
      AluXor:  result = opa ^ opb;
      AluSll:  result = opa << shamt;
      AluSrl:  result = opa >> shamt;
      AluSra:  result = $unsigned($signed(opa) >>> shamt);
`ifdef ALU_PIPE_ZBB_EN
      AluMin:  result = lt_s ? opa : opb;
      AluMax:  result = lt_s ? opb : opa;
      AluMinu: result = lt_u ? opa : opb;
      AluMaxu: result = lt_u ? opb : opa;
      AluAndn: result = opa & ~opb;
      AluOrn:  result = opa | ~opb;
`endif
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer ALU functional unit: computes in the accept cycle, then carries the
// result through STAGES registers to the CDB with valid/ready back-pressure. Each entry
// holds a branch mask so it can be squashed or have resolved bits cleared in flight.
// Optional feature macro: ALU_PIPE_ZBB_EN (forwarded to alu_pipe_core).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDefault,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = TagWDefault,
  parameter int unsigned BM_W   = BmWDefault
) (
  input logic       clock,
  input logic       reset_n,
  alu_pipe_if.slave bus
);
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic [BM_W-1:0]  bmask;
  } entry_t;

  entry_t            stage_q [STAGES];
  entry_t            stage_d [STAGES];
  logic [STAGES-1:0] adv;
  logic              accept_slot;
  logic [XLEN-1:0]   core_result;

  alu_pipe_core #(
    .XLEN(XLEN)
  ) u_core (
    .opa   (bus.in_opa),
    .opb   (bus.in_opb),
    .func  (bus.in_func),
    .result(core_result)
  );

  // Squash is tested against the mask before the resolve clear, so squash wins on a shared bit.
  function automatic entry_t branch_update(entry_t e, logic sq_v, logic [BM_W-1:0] sq_m,
                                           logic rs_v, logic [BM_W-1:0] rs_m);
    entry_t r;
    r = e;
    if (sq_v && |(e.bmask & sq_m)) r.valid = 1'b0;
    if (rs_v) r.bmask = e.bmask & ~rs_m;
    return r;
  endfunction

  // Advance chain from the output backwards: a stage moves when the one ahead is free or moving.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = stage_q[STAGES-1].valid & bus.out_ready;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      adv[i] = stage_q[i].valid & (~stage_q[i+1].valid | adv[i+1]);
    end
    accept_slot = ~stage_q[0].valid | adv[0];
  end

  // Next-state: load each stage from behind when it is empty or draining, then apply branches.
  always_comb begin
    for (int i = 0; i < int'(STAGES); i++) stage_d[i] = stage_q[i];
    if (accept_slot) begin
      stage_d[0].valid  = bus.in_valid;
      stage_d[0].result = core_result;
      stage_d[0].tag    = bus.in_tag;
      stage_d[0].bmask  = bus.in_bmask;
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      // If stage i-1 is empty this copies a bubble, which is how bubbles collapse.
      if (~stage_q[i].valid | adv[i]) stage_d[i] = stage_q[i-1];
    end
    for (int i = 0; i < int'(STAGES); i++) begin
      stage_d[i] = branch_update(stage_d[i], bus.squash_valid, bus.squash_bmask,
                                 bus.resolve_valid, bus.resolve_bmask);
    end
  end

  // Pipeline registers; reset clears every entry immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= stage_d[i];
    end
  end

  // Outputs come from the last stage; busy is the OR of all valid bits.
  always_comb begin
    bus.in_ready   = accept_slot;
    bus.out_valid  = stage_q[STAGES-1].valid;
    bus.out_result = stage_q[STAGES-1].result;
    bus.out_tag    = stage_q[STAGES-1].tag;
    bus.out_bmask  = stage_q[STAGES-1].bmask;
    bus.busy       = 1'b0;
    for (int i = 0; i < int'(STAGES); i++) bus.busy = bus.busy | stage_q[i].valid;
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized run checked
// against a queue-based reference model. Honors ALU_PIPE_ZBB_EN in its expectations.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  alu_pipe_if #(.XLEN(32), .TAG_W(6), .BM_W(4)) bus ();
  alu_pipe_if #(.XLEN(64), .TAG_W(6), .BM_W(4)) bus64 ();

  alu_pipe #(.XLEN(32), .STAGES(2), .TAG_W(6), .BM_W(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  alu_pipe #(.XLEN(64), .STAGES(3), .TAG_W(6), .BM_W(4)) dut64 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus64)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  tag;
    logic [3:0]  bm;
  } exp_t;

  exp_t mq[$];

  // Reference ALU from the arithmetic rules, evaluated in 64-bit then truncated to xlen.
  function automatic logic [63:0] ref_alu(input int xlen, input logic [3:0] f,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, r;
    longint sa, sb;
    int sh;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    sa = (xlen == 64) ? longint'(a) : longint'({{32{a[31]}}, a[31:0]});
    sb = (xlen == 64) ? longint'(b) : longint'({{32{b[31]}}, b[31:0]});
    sh = (xlen == 64) ? int'(b[5:0]) : int'(b[4:0]);
    case (f)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd3: r = (a < b) ? 64'd1 : 64'd0;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = 64'(sa >>> sh);
`ifdef ALU_PIPE_ZBB_EN
      4'd10: r = (sa < sb) ? a : b;
      4'd11: r = (sa > sb) ? a : b;
      4'd12: r = (a < b) ? a : b;
      4'd13: r = (a > b) ? a : b;
      4'd14: r = a & ~b;
      4'd15: r = a | ~b;
`endif
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  function automatic logic [63:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_8000_0000;
      3: return 64'd31;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic idle32();
    bus.in_valid = 1'b0; bus.in_func = 4'd0; bus.in_opa = '0; bus.in_opb = '0;
    bus.in_tag = '0; bus.in_bmask = '0;
    bus.squash_valid = 1'b0; bus.squash_bmask = '0;
    bus.resolve_valid = 1'b0; bus.resolve_bmask = '0;
  endtask

  task automatic idle64();
    bus64.in_valid = 1'b0; bus64.in_func = 4'd0; bus64.in_opa = '0; bus64.in_opb = '0;
    bus64.in_tag = '0; bus64.in_bmask = '0;
    bus64.squash_valid = 1'b0; bus64.squash_bmask = '0;
    bus64.resolve_valid = 1'b0; bus64.resolve_bmask = '0;
  endtask

  task automatic drive32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input logic [3:0] bm);
    bus.in_valid = 1'b1; bus.in_func = f; bus.in_opa = a; bus.in_opb = b;
    bus.in_tag = tag; bus.in_bmask = bm;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if ({bus.out_result, bus.out_tag, bus.out_bmask} !== 42'd0) begin
      n_err++; $display("FAIL reset_out_data: got %h/%h/%h want 0", bus.out_result,
                        bus.out_tag, bus.out_bmask);
    end
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    drive32(4'd0, 32'd5, 32'd7, 6'd1, 4'd0);
    @(posedge clock); #1;
    drive32(4'd1, 32'd3, 32'd5, 6'd2, 4'd0);
    @(negedge clock);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_latency_early: out_valid %b want 0", bus.out_valid);
    end
    @(posedge clock); #1;
    drive32(4'd9, 32'h8000_0000, 32'd4, 6'd3, 4'd0);
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.out_result, bus.out_tag} !== {1'b1, 32'd12, 6'd1}) begin
      n_err++; $display("FAIL stream_add: got v%b %h t%0d want v1 0000000c t1",
                        bus.out_valid, bus.out_result, bus.out_tag);
    end
    @(posedge clock); #1;
    idle32();
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.out_result, bus.out_tag} !== {1'b1, 32'hFFFF_FFFE, 6'd2}) begin
      n_err++; $display("FAIL stream_sub: got v%b %h t%0d want v1 fffffffe t2",
                        bus.out_valid, bus.out_result, bus.out_tag);
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.out_result, bus.out_tag} !== {1'b1, 32'hF800_0000, 6'd3}) begin
      n_err++; $display("FAIL stream_sra: got v%b %h t%0d want v1 f8000000 t3",
                        bus.out_valid, bus.out_result, bus.out_tag);
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      n_err++; $display("FAIL stream_empty: got v%b busy%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r[3];
    logic [5:0]  exp_t[3];
    int got = 0;
    bit acc;
    exp_r[0] = 32'd123;    exp_t[0] = 6'd5;
    exp_r[1] = 32'h0000_FF00; exp_t[1] = 6'd6;
    exp_r[2] = 32'd1;      exp_t[2] = 6'd7;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    drive32(4'd0, 32'd100, 32'd23, 6'd5, 4'd0);
    @(posedge clock); #1;
    drive32(4'd6, 32'h0000_F0F0, 32'h0000_0FF0, 6'd6, 4'd0);
    @(posedge clock); #1;
    drive32(4'd2, 32'hFFFF_FFFF, 32'd1, 6'd7, 4'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag} !==
          {1'b0, 1'b1, exp_r[0], exp_t[0]}) begin
        n_err++; $display("FAIL bp_hold[%0d]: rdy%b v%b %h t%0d want rdy0 v1 %h t%0d", c,
                          bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag,
                          exp_r[0], exp_t[0]);
      end
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (got >= 3) begin
          n_err++; $display("FAIL bp_extra: unexpected result %h", bus.out_result);
        end else if ({bus.out_result, bus.out_tag} !== {exp_r[got], exp_t[got]}) begin
          n_err++; $display("FAIL bp_drain[%0d]: got %h t%0d want %h t%0d", got,
                            bus.out_result, bus.out_tag, exp_r[got], exp_t[got]);
        end
        got++;
      end
      @(posedge clock); #1;
      if (acc) bus.in_valid = 1'b0;
    end
    n_cmp++;
    if (got != 3) begin
      n_err++; $display("FAIL bp_count: got %0d results want 3", got);
    end
    idle32();
  endtask

  task automatic test_squash();
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    drive32(4'd0, 32'd1, 32'd1, 6'd11, 4'b0010);
    @(posedge clock); #1;
    drive32(4'd1, 32'd9, 32'd4, 6'd12, 4'b0100);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.squash_valid = 1'b1; bus.squash_bmask = 4'b0010;
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.out_tag} !== {1'b1, 6'd11}) begin
      n_err++; $display("FAIL sq_pre: v%b t%0d want v1 t11", bus.out_valid, bus.out_tag);
    end
    @(posedge clock); #1;
    bus.squash_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.busy} !== 2'b01) begin
      n_err++; $display("FAIL sq_gone: v%b busy%b want v0 busy1", bus.out_valid, bus.busy);
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.out_tag, bus.out_result} !== {1'b1, 6'd12, 32'd5}) begin
      n_err++; $display("FAIL sq_survivor: v%b t%0d %h want v1 t12 00000005",
                        bus.out_valid, bus.out_tag, bus.out_result);
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    // Accept and squash the same op.
    drive32(4'd0, 32'd2, 32'd2, 6'd13, 4'b1000);
    bus.squash_valid = 1'b1; bus.squash_bmask = 4'b1000;
    @(negedge clock);
    n_cmp++;
    if ({bus.in_ready, bus.busy} !== 2'b10) begin
      n_err++; $display("FAIL sq_accept_rdy: rdy%b busy%b want rdy1 busy0",
                        bus.in_ready, bus.busy);
    end
    @(posedge clock); #1;
    idle32();
    @(negedge clock);
    n_cmp++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      n_err++; $display("FAIL sq_accept_gone: busy%b v%b want 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_squash_resolve();
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    drive32(4'd4, 32'hFF, 32'h0F, 6'd21, 4'b0110);
    @(posedge clock); #1;
    drive32(4'd5, 32'hF0, 32'h0F, 6'd22, 4'b0100);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.squash_valid = 1'b1;  bus.squash_bmask = 4'b0010;
    bus.resolve_valid = 1'b1; bus.resolve_bmask = 4'b0100;
    @(posedge clock); #1;
    idle32();
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.busy} !== 2'b01) begin
      n_err++; $display("FAIL sr_squash_wins: v%b busy%b want v0 busy1",
                        bus.out_valid, bus.busy);
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.out_tag, bus.out_bmask, bus.out_result} !==
        {1'b1, 6'd22, 4'b0000, 32'hFF}) begin
      n_err++; $display("FAIL sr_resolved: v%b t%0d bm%b %h want v1 t22 bm0000 000000ff",
                        bus.out_valid, bus.out_tag, bus.out_bmask, bus.out_result);
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL sr_drain: busy %b want 0", bus.busy);
    end
  endtask

  task automatic test_xlen64();
    logic [3:0]  f[4];
    logic [63:0] a[4], b[4], ex[4];
    int got = 0;
    int first = -1;
    f[0] = 4'd7;  a[0] = 64'd1; b[0] = 64'd63; ex[0] = 64'h8000_0000_0000_0000;
    f[1] = 4'd3;  a[1] = 64'd0; b[1] = 64'hFFFF_FFFF_FFFF_FFFF; ex[1] = 64'd1;
    f[2] = 4'd12; a[2] = 64'd3; b[2] = 64'd9;
`ifdef ALU_PIPE_ZBB_EN
    ex[2] = 64'd3;
`else
    ex[2] = 64'd0;
`endif
    f[3] = 4'd9; a[3] = 64'h8000_0000_0000_0000; b[3] = 64'd8;
    ex[3] = 64'hFF80_0000_0000_0000;
    bus64.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (c < 4) begin
        bus64.in_valid = 1'b1; bus64.in_func = f[c]; bus64.in_opa = a[c];
        bus64.in_opb = b[c]; bus64.in_tag = 6'(40 + c); bus64.in_bmask = 4'd0;
      end else begin
        idle64();
      end
      @(negedge clock);
      if (c < 4) begin
        n_cmp++;
        if (bus64.in_ready !== 1'b1) begin
          n_err++; $display("FAIL x64_in_ready[%0d]: got %b want 1", c, bus64.in_ready);
        end
      end
      if (bus64.out_valid === 1'b1) begin
        if (first < 0) first = c;
        n_cmp++;
        if (got >= 4) begin
          n_err++; $display("FAIL x64_extra: %h", bus64.out_result);
        end else if ({bus64.out_result, bus64.out_tag} !== {ex[got], 6'(40 + got)}) begin
          n_err++; $display("FAIL x64_result[%0d]: got %h t%0d want %h t%0d", got,
                            bus64.out_result, bus64.out_tag, ex[got], 40 + got);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 4 || first != 3) begin
      n_err++; $display("FAIL x64_count_latency: got %0d first@%0d want 4 first@3", got, first);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [3:0] sq;
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      if (c < 360) begin
        drive32(4'($urandom_range(0, 15)), pick_op(), pick_op(), 6'($urandom),
                4'($urandom));
        bus.in_valid      = ($urandom_range(0, 3) != 0);
        bus.squash_valid  = ($urandom_range(0, 7) == 0);
        bus.squash_bmask  = 4'(1 << $urandom_range(0, 3));
        bus.resolve_valid = ($urandom_range(0, 5) == 0);
        bus.resolve_bmask = 4'(1 << $urandom_range(0, 3));
        bus.out_ready     = ($urandom_range(0, 3) != 0);
      end else begin
        idle32();
        bus.out_ready = 1'b1;
      end
      @(negedge clock);
      n_cmp++;
      if (bus.busy !== (mq.size() != 0)) begin
        n_err++; $display("FAIL rnd_busy@%0d: got %b want %b", c, bus.busy, mq.size() != 0);
      end
      if (bus.out_valid === 1'b1) begin
        n_cmp++;
        if (mq.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious@%0d: out_valid with nothing in flight", c);
        end else begin
          if ({bus.out_result, bus.out_tag, bus.out_bmask} !==
              {mq[0].res[31:0], mq[0].tag, mq[0].bm}) begin
            n_err++; $display("FAIL rnd_out@%0d: got %h t%0d bm%b want %h t%0d bm%b", c,
                              bus.out_result, bus.out_tag, bus.out_bmask,
                              mq[0].res[31:0], mq[0].tag, mq[0].bm);
          end
          if (bus.out_ready === 1'b1) void'(mq.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.res = ref_alu(32, bus.in_func, {32'd0, bus.in_opa}, {32'd0, bus.in_opb});
        e.tag = bus.in_tag;
        e.bm  = bus.in_bmask;
        mq.push_back(e);
      end
      if (bus.squash_valid) begin
        sq = bus.squash_bmask;
        for (int i = mq.size() - 1; i >= 0; i--) if ((mq[i].bm & sq) != 4'd0) mq.delete(i);
      end
      if (bus.resolve_valid) begin
        foreach (mq[i]) mq[i].bm = mq[i].bm & ~bus.resolve_bmask;
      end
    end
    n_cmp++;
    if (mq.size() != 0) begin
      n_err++; $display("FAIL rnd_leftover: %0d entries never completed", mq.size());
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    drive32(4'd0, 32'd1, 32'd2, 6'd31, 4'd0);
    @(posedge clock); #1;
    drive32(4'd0, 32'd3, 32'd4, 6'd32, 4'd0);
    @(posedge clock); #1;
    idle32();
    @(negedge clock);
    n_cmp++;
    if ({bus.out_valid, bus.busy} !== 2'b11) begin
      n_err++; $display("FAIL ar_pre: v%b busy%b want 1 1", bus.out_valid, bus.busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      n_err++; $display("FAIL ar_async: v%b busy%b rdy%b want 0 0 1",
                        bus.out_valid, bus.busy, bus.in_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      n_err++; $display("FAIL ar_after: rdy%b busy%b v%b want 1 0 0",
                        bus.in_ready, bus.busy, bus.out_valid);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle32();
    idle64();
    bus.out_ready = 1'b1;
    bus64.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_squash();
    test_squash_resolve();
    test_xlen64();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
